keypad_matrix_scan: RTL and testbench

- Scans a 4x4 membrane keypad, debounces it and encodes the pressed key into the 4-bit key code plus press flag consumed by the electronic-organ decoder.
- Codes 1..7 select notes; A/B/C select low/mid/high scale.
- Sits between the keypad I/O pins and the music/LCD logic in the 100 MHz clk domain.

---
 rtl/keypad_pkg.sv | 46 ++++
 rtl/keypad_debounce.sv | 65 ++++++
 rtl/keypad_matrix_scan.sv | 127 ++++++++++++
 tb/tb_keypad_matrix_scan.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: map/code types, the position-to-code table and
// the named codes the music decoder interprets.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef logic [NUM_KEYS-1:0] key_map_t;
  typedef logic [3:0]          key_idx_t;
  typedef logic [3:0]          key_code_t;

  localparam key_code_t KEY_SCALE_LO  = 4'hA;
  localparam key_code_t KEY_SCALE_MID = 4'hB;
  localparam key_code_t KEY_SCALE_HI  = 4'hC;

  localparam key_code_t KEY_NOTE_MIN = 4'h1;
  localparam key_code_t KEY_NOTE_MAX = 4'h7;

  // Indexed by row*4 + col; matches the printed legend of the membrane pad.
  localparam key_code_t KEY_CODE_TABLE [NUM_KEYS] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic key_code_t key_code(input key_idx_t idx);
    return KEY_CODE_TABLE[idx];
  endfunction

  function automatic logic is_note_code(input key_code_t code);
    return (code >= KEY_NOTE_MIN) && (code <= KEY_NOTE_MAX);
  endfunction

  // Lowest set index wins: lower row first, then lower column.
  function automatic key_idx_t lowest_key(input key_map_t map);
    key_idx_t idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (map[i]) idx = key_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-frame debouncer: the debounced map only follows the raw map after it
// has been identical for DEBOUNCE_FRAMES consecutive frame comparisons.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 5
) (
  input  logic     clk,
  input  logic     sys_rst_n,
  input  key_map_t raw_map,
  input  logic     frame_done,
  output key_map_t deb_map,
  output logic     deb_update
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  key_map_t         prev_map_q, prev_map_d;
  key_map_t         deb_map_q, deb_map_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic             deb_update_q, deb_update_d;

  always_comb begin
    prev_map_d   = prev_map_q;
    deb_map_d    = deb_map_q;
    stable_cnt_d = stable_cnt_q;
    deb_update_d = 1'b0;
    if (frame_done) begin
      if (raw_map == prev_map_q) begin
        if (stable_cnt_q != CNT_MAX) begin
          stable_cnt_d = stable_cnt_q + CNT_ONE;
          // Reaching the threshold is the only moment the debounced map moves.
          if (stable_cnt_q == CNT_LAST) begin
            deb_map_d    = prev_map_q;
            deb_update_d = 1'b1;
          end
        end
      end else begin
        prev_map_d   = raw_map;
        stable_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev_map_q   <= '0;
      deb_map_q    <= '0;
      stable_cnt_q <= '0;
      deb_update_q <= 1'b0;
    end else begin
      prev_map_q   <= prev_map_d;
      deb_map_q    <= deb_map_d;
      stable_cnt_q <= stable_cnt_d;
      deb_update_q <= deb_update_d;
    end
  end

  assign deb_map    = deb_map_q;
  assign deb_update = deb_update_q;

endmodule

// File: rtl/keypad_matrix_scan.sv
// 4x4 keypad scanner: drives one row low at a time, samples synchronized
// columns into a raw map, debounces per frame and encodes the winning key.
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int unsigned ROW_DWELL_CYCLES = 100000,
  parameter int unsigned DEBOUNCE_FRAMES  = 5
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] keyboard_data,
  output logic       is_pressed,
  output logic       key_valid
);

  localparam int unsigned DWELL_W = $clog2(ROW_DWELL_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  logic [3:0]         col_meta_q, col_sync_q;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [1:0]         row_q, row_d;
  logic [3:0]         row_n_q, row_n_d;
  key_map_t           raw_map_q, raw_map_d;
  logic               frame_done_q, frame_done_d;
  logic               row_sample;

  key_map_t           deb_map;
  logic               deb_update;
  key_code_t          win_code;

  key_code_t          kb_data_q, kb_data_d;
  logic               pressed_q, pressed_d;
  logic               valid_q, valid_d;

  // Columns float relative to clk; two flops before anything looks at them.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
    end
  end

  assign row_sample = (dwell_cnt_q == DWELL_LAST);

  always_comb begin
    dwell_cnt_d  = dwell_cnt_q + DWELL_ONE;
    row_d        = row_q;
    raw_map_d    = raw_map_q;
    frame_done_d = 1'b0;
    if (row_sample) begin
      dwell_cnt_d                            = '0;
      row_d                                  = row_q + 2'd1;
      raw_map_d[{row_q, 2'b00} +: NUM_COLS]  = ~col_sync_q;
      frame_done_d                           = (row_q == 2'd3);
    end
    row_n_d = ~(4'b0001 << row_d);
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dwell_cnt_q  <= '0;
      row_q        <= 2'd0;
      row_n_q      <= 4'b1110;
      raw_map_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      dwell_cnt_q  <= dwell_cnt_d;
      row_q        <= row_d;
      row_n_q      <= row_n_d;
      raw_map_q    <= raw_map_d;
      frame_done_q <= frame_done_d;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .raw_map    (raw_map_q),
    .frame_done (frame_done_q),
    .deb_map    (deb_map),
    .deb_update (deb_update)
  );

  assign win_code = key_code(lowest_key(deb_map));

  // On release the code is held so the selected scale survives key-up.
  always_comb begin
    kb_data_d = kb_data_q;
    pressed_d = pressed_q;
    valid_d   = 1'b0;
    if (deb_update) begin
      if (deb_map != '0) begin
        kb_data_d = win_code;
        pressed_d = 1'b1;
        valid_d   = !pressed_q || (win_code != kb_data_q);
      end else begin
        pressed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      kb_data_q <= 4'h0;
      pressed_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      kb_data_q <= kb_data_d;
      pressed_q <= pressed_d;
      valid_q   <= valid_d;
    end
  end

  assign row_n         = row_n_q;
  assign keyboard_data = kb_data_q;
  assign is_pressed    = pressed_q;
  assign key_valid     = valid_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan with dwell 8 and 3 debounce frames;
// a behavioural switch matrix closes columns against the driven row.
`timescale 1ns/1ps
module tb_keypad_matrix_scan;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  keyboard_data;
  logic        is_pressed;
  logic        key_valid;
  logic [15:0] keys = 16'h0;

  int nchecks = 0;
  int nerrors = 0;
  int vcount  = 0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[20];

  always #5 clk = ~clk;

  keypad_matrix_scan #(
    .ROW_DWELL_CYCLES (8),
    .DEBOUNCE_FRAMES  (3)
  ) dut (
    .clk           (clk),
    .sys_rst_n     (sys_rst_n),
    .col_n         (col_n),
    .row_n         (row_n),
    .keyboard_data (keyboard_data),
    .is_pressed    (is_pressed),
    .key_valid     (key_valid)
  );

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk) if (key_valid === 1'b1) vcount++;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just after row 0 becomes active again.
  task automatic wait_frame_start();
    int guard;
    guard = 0;
    while (row_n !== 4'b0111 && guard < 200) begin @(negedge clk); guard++; end
    while (row_n !== 4'b1110 && guard < 200) begin @(negedge clk); guard++; end
    nchecks++;
    if (guard >= 200) begin
      nerrors++;
      $display("FAIL frame_sync: row_n %b never reached frame start", row_n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int drops;

    vecs[0]  = '{16'h0001, 4'h1};  vecs[1]  = '{16'h0002, 4'h2};
    vecs[2]  = '{16'h0004, 4'h3};  vecs[3]  = '{16'h0008, 4'hA};
    vecs[4]  = '{16'h0010, 4'h4};  vecs[5]  = '{16'h0020, 4'h5};
    vecs[6]  = '{16'h0040, 4'h6};  vecs[7]  = '{16'h0080, 4'hB};
    vecs[8]  = '{16'h0100, 4'h7};  vecs[9]  = '{16'h0200, 4'h8};
    vecs[10] = '{16'h0400, 4'h9};  vecs[11] = '{16'h0800, 4'hC};
    vecs[12] = '{16'h1000, 4'hE};  vecs[13] = '{16'h2000, 4'h0};
    vecs[14] = '{16'h4000, 4'hF};  vecs[15] = '{16'h8000, 4'hD};
    vecs[16] = '{16'h00A0, 4'h5};  vecs[17] = '{16'h9000, 4'hE};
    vecs[18] = '{16'h0018, 4'hA};  vecs[19] = '{16'h4400, 4'h9};

    // Reset values and row timing
    tick(3);
    check("rst_row_n", row_n, 4'b1110);
    check("rst_kb", keyboard_data, 4'h0);
    check("rst_pressed", is_pressed, 1'b0);
    check("rst_valid", key_valid, 1'b0);
    sys_rst_n = 1'b1;
    tick(7);
    check("row0_dwell_end", row_n, 4'b1110);
    tick(1);
    check("row1_start", row_n, 4'b1101);
    tick(7);
    check("row1_dwell_end", row_n, 4'b1101);
    tick(1);
    check("row2_start", row_n, 4'b1011);
    tick(15);
    check("row3_dwell_end", row_n, 4'b0111);
    tick(1);
    check("row0_return", row_n, 4'b1110);

    // Single keys and chords: press, hold, release
    for (int i = 0; i < 20; i++) begin
      wait_frame_start();
      keys = vecs[i].keys;
      snap = vcount;
      tick(129);
      check($sformatf("v%0d_early_pressed", i), is_pressed, 1'b0);
      tick(1);
      check($sformatf("v%0d_pressed", i), is_pressed, 1'b1);
      check($sformatf("v%0d_code", i), keyboard_data, vecs[i].code);
      check($sformatf("v%0d_valid", i), key_valid, 1'b1);
      tick(1);
      check($sformatf("v%0d_valid_off", i), key_valid, 1'b0);
      wait_frame_start();
      keys = 16'h0;
      tick(129);
      check($sformatf("v%0d_rel_still", i), is_pressed, 1'b1);
      tick(1);
      check($sformatf("v%0d_released", i), is_pressed, 1'b0);
      check($sformatf("v%0d_code_held", i), keyboard_data, vecs[i].code);
      tick(5);
      check($sformatf("v%0d_valid_count", i), 16'(vcount - snap), 16'd1);
    end

    // Bounce on key 1: toggles every 20 cycles for 3 frames, then steady
    wait_frame_start();
    snap = vcount;
    drops = 0;
    keys = 16'h0001;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (is_pressed) drops++;
      end
      keys[0] = ~keys[0];
    end
    tick(16);
    check("bounce_steady_at_frame", row_n, 4'b1110);
    for (int k = 0; k < 129; k++) begin
      @(negedge clk);
      if (is_pressed) drops++;
    end
    check("bounce_no_early_press", 16'(drops), 16'd0);
    tick(1);
    check("bounce_pressed", is_pressed, 1'b1);
    check("bounce_code", keyboard_data, 4'h1);
    tick(3);
    check("bounce_valid_count", 16'(vcount - snap), 16'd1);
    wait_frame_start();
    keys = 16'h0;
    tick(131);
    check("bounce_released", is_pressed, 1'b0);

    // Chord B+5, then release 5 with B still held
    wait_frame_start();
    snap = vcount;
    keys = 16'h00A0;
    tick(131);
    check("chord_code", keyboard_data, 4'h5);
    check("chord_pressed", is_pressed, 1'b1);
    wait_frame_start();
    keys = 16'h0080;
    drops = 0;
    for (int k = 0; k < 129; k++) begin
      @(negedge clk);
      if (!is_pressed) drops++;
    end
    check("chord_old_code", keyboard_data, 4'h5);
    tick(1);
    check("chord_new_code", keyboard_data, 4'hB);
    check("chord_new_valid", key_valid, 1'b1);
    check("chord_no_drop", 16'(drops + (is_pressed ? 0 : 1)), 16'd0);
    tick(2);
    check("chord_valid_count", 16'(vcount - snap), 16'd2);

    // Reset in the middle of debouncing key 3
    wait_frame_start();
    keys = 16'h0004;
    tick(64);
    check("pre_rst_kb", keyboard_data, 4'hB);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_row_n", row_n, 4'b1110);
    check("midrst_kb", keyboard_data, 4'h0);
    check("midrst_pressed", is_pressed, 1'b0);
    check("midrst_valid", key_valid, 1'b0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    snap = vcount;
    tick(129);
    check("midrst_early", is_pressed, 1'b0);
    tick(1);
    check("midrst_pressed_after", is_pressed, 1'b1);
    check("midrst_code", keyboard_data, 4'h3);
    tick(2);
    check("midrst_valid_count", 16'(vcount - snap), 16'd1);
    wait_frame_start();
    keys = 16'h0;
    tick(131);

    // Scale key A, release, then note 7
    snap = vcount;
    wait_frame_start();
    keys = 16'h0008;
    tick(131);
    check("scale_a_code", keyboard_data, 4'hA);
    check("scale_a_pressed", is_pressed, 1'b1);
    wait_frame_start();
    keys = 16'h0;
    tick(131);
    check("scale_a_held", keyboard_data, 4'hA);
    check("scale_a_released", is_pressed, 1'b0);
    wait_frame_start();
    keys = 16'h0100;
    tick(131);
    check("note7_code", keyboard_data, 4'h7);
    check("note7_pressed", is_pressed, 1'b1);
    check("scale_valid_count", 16'(vcount - snap), 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
